// File: rtl/tnoc_axi_read_request_arbiter.sv
// Round-robin arbiter sharing one AXI AR/R channel pair among several local masters.
// AR payload is registered in a two-state ARB/HOLD stage; R beats route back by the upper RID bits.
module tnoc_axi_read_request_arbiter #(
    parameter int REQUESTERS      = 4,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 256,
    parameter int MAX_OUTSTANDING = 8,
    localparam int IDX_WIDTH      = $clog2(REQUESTERS),
    localparam int M_ID_WIDTH     = IDX_WIDTH + ID_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQUESTERS-1:0]          s_arvalid,
    output logic [REQUESTERS-1:0]          s_arready,
    input  logic [REQUESTERS*ID_WIDTH-1:0] s_arid,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] s_araddr,
    input  logic [REQUESTERS*8-1:0]        s_arlen,
    input  logic [REQUESTERS*3-1:0]        s_arsize,
    input  logic [REQUESTERS*2-1:0]        s_arburst,
    output logic                           m_arvalid,
    input  logic                           m_arready,
    output logic [M_ID_WIDTH-1:0]          m_arid,
    output logic [ADDR_WIDTH-1:0]          m_araddr,
    output logic [7:0]                     m_arlen,
    output logic [2:0]                     m_arsize,
    output logic [1:0]                     m_arburst,
    input  logic                           m_rvalid,
    output logic                           m_rready,
    input  logic [M_ID_WIDTH-1:0]          m_rid,
    input  logic [DATA_WIDTH-1:0]          m_rdata,
    input  logic [1:0]                     m_rresp,
    input  logic                           m_rlast,
    output logic [REQUESTERS-1:0]          s_rvalid,
    input  logic [REQUESTERS-1:0]          s_rready,
    output logic [ID_WIDTH-1:0]            s_rid,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rlast,
    output logic                           o_route_error
);

    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(REQUESTERS - 1);

    typedef enum logic {ARB, HOLD} state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   ptr;
    logic [IDX_WIDTH-1:0]   winner;
    logic [IDX_WIDTH-1:0]   cand;
    logic [IDX_WIDTH-1:0]   r_idx;
    logic                   found;
    logic                   r_idx_ok;
    logic [REQUESTERS-1:0]  eligible;
    logic [REQUESTERS-1:0]  r_done;
    logic [CNT_WIDTH-1:0]   cnt [REQUESTERS];

    // A requester at its outstanding limit is invisible to the arbiter.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            eligible[i] = s_arvalid[i] && (cnt[i] < CNT_MAX);
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            cand = IDX_WIDTH'((int'(ptr) + k) % REQUESTERS);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        s_arready = '0;
        if (!rst && state == ARB && found) begin
            s_arready[winner] = 1'b1;
        end
    end

    // Beats carrying an index with no requester behind it are swallowed.
    assign r_idx    = m_rid[M_ID_WIDTH-1 -: IDX_WIDTH];
    assign r_idx_ok = int'(r_idx) < REQUESTERS;

    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b1;
        r_done   = '0;
        if (r_idx_ok) begin
            s_rvalid[r_idx] = m_rvalid;
            m_rready        = s_rready[r_idx];
            r_done[r_idx]   = m_rvalid && s_rready[r_idx] && m_rlast;
        end
    end

    assign s_rid   = m_rid[ID_WIDTH-1:0];
    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB;
            ptr           <= '0;
            m_arvalid     <= 1'b0;
            m_arid        <= '0;
            m_araddr      <= '0;
            m_arlen       <= '0;
            m_arsize      <= '0;
            m_arburst     <= '0;
            o_route_error <= 1'b0;
            for (int i = 0; i < REQUESTERS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            o_route_error <= m_rvalid && !r_idx_ok;
            case (state)
                ARB: begin
                    if (found) begin
                        state     <= HOLD;
                        m_arvalid <= 1'b1;
                        m_arid    <= {winner, s_arid[winner*ID_WIDTH +: ID_WIDTH]};
                        m_araddr  <= s_araddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        m_arlen   <= s_arlen[winner*8 +: 8];
                        m_arsize  <= s_arsize[winner*3 +: 3];
                        m_arburst <= s_arburst[winner*2 +: 2];
                        ptr       <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
                    end
                end
                HOLD: begin
                    if (m_arready) begin
                        state     <= ARB;
                        m_arvalid <= 1'b0;
                    end
                end
                default: state <= ARB;
            endcase
            // A grant and a burst completion for the same requester cancel out.
            for (int i = 0; i < REQUESTERS; i++) begin
                if (s_arvalid[i] && s_arready[i] && !r_done[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (r_done[i] && !(s_arvalid[i] && s_arready[i]) && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tnoc_axi_read_request_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared to a transaction-level model.
module tb_tnoc_axi_read_request_arbiter;

    localparam int R    = 4;
    localparam int IDW  = 4;
    localparam int AW   = 64;
    localparam int DW   = 256;
    localparam int MO   = 8;
    localparam int MIDW = 6;
    localparam int R3   = 3;
    localparam int AW3  = 32;
    localparam int DW3  = 32;
    localparam int MO3  = 2;

    logic clk = 1'b0;
    logic rst;

    logic [R-1:0]     s_arvalid, s_arready, s_rvalid, s_rready;
    logic [R*IDW-1:0] s_arid;
    logic [R*AW-1:0]  s_araddr;
    logic [R*8-1:0]   s_arlen;
    logic [R*3-1:0]   s_arsize;
    logic [R*2-1:0]   s_arburst;
    logic             m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, s_rlast, o_route_error;
    logic [MIDW-1:0]  m_arid, m_rid;
    logic [AW-1:0]    m_araddr;
    logic [7:0]       m_arlen;
    logic [2:0]       m_arsize;
    logic [1:0]       m_arburst, m_rresp, s_rresp;
    logic [DW-1:0]    m_rdata, s_rdata;
    logic [IDW-1:0]   s_rid;

    logic [R3-1:0]     c_s_arvalid, c_s_arready, c_s_rvalid, c_s_rready;
    logic [R3*IDW-1:0] c_s_arid;
    logic [R3*AW3-1:0] c_s_araddr;
    logic [R3*8-1:0]   c_s_arlen;
    logic [R3*3-1:0]   c_s_arsize;
    logic [R3*2-1:0]   c_s_arburst;
    logic              c_m_arvalid, c_m_arready, c_m_rvalid, c_m_rready, c_m_rlast, c_s_rlast, c_o_route_error;
    logic [MIDW-1:0]   c_m_arid, c_m_rid;
    logic [AW3-1:0]    c_m_araddr;
    logic [7:0]        c_m_arlen;
    logic [2:0]        c_m_arsize;
    logic [1:0]        c_m_arburst, c_m_rresp, c_s_rresp;
    logic [DW3-1:0]    c_m_rdata, c_s_rdata;
    logic [IDW-1:0]    c_s_rid;

    int n_err = 0;
    int n_checks = 0;

    // Reference model state: one AR in flight downstream, rotating priority, per-requester burst counts.
    bit              exp_busy;
    int              exp_ptr;
    int              exp_cnt [R];
    logic [MIDW-1:0] exp_arid;
    logic [AW-1:0]   exp_araddr;
    logic [7:0]      exp_arlen;
    logic [2:0]      exp_arsize;
    logic [1:0]      exp_arburst;
    logic [R-1:0]    p_s_arready, p_s_rvalid;
    logic            p_m_rready;
    int              p_winner;

    always #5 clk = ~clk;

    tnoc_axi_read_request_arbiter #(
        .REQUESTERS(R), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .o_route_error(o_route_error)
    );

    tnoc_axi_read_request_arbiter #(
        .REQUESTERS(R3), .ID_WIDTH(IDW), .ADDR_WIDTH(AW3), .DATA_WIDTH(DW3), .MAX_OUTSTANDING(MO3)
    ) dut3 (
        .clk(clk), .rst(rst),
        .s_arvalid(c_s_arvalid), .s_arready(c_s_arready), .s_arid(c_s_arid), .s_araddr(c_s_araddr),
        .s_arlen(c_s_arlen), .s_arsize(c_s_arsize), .s_arburst(c_s_arburst),
        .m_arvalid(c_m_arvalid), .m_arready(c_m_arready), .m_arid(c_m_arid), .m_araddr(c_m_araddr),
        .m_arlen(c_m_arlen), .m_arsize(c_m_arsize), .m_arburst(c_m_arburst),
        .m_rvalid(c_m_rvalid), .m_rready(c_m_rready), .m_rid(c_m_rid), .m_rdata(c_m_rdata),
        .m_rresp(c_m_rresp), .m_rlast(c_m_rlast),
        .s_rvalid(c_s_rvalid), .s_rready(c_s_rready), .s_rid(c_s_rid), .s_rdata(c_s_rdata),
        .s_rresp(c_s_rresp), .s_rlast(c_s_rlast), .o_route_error(c_o_route_error)
    );

    task automatic model_reset();
        exp_busy = 1'b0;
        exp_ptr  = 0;
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        exp_arid    = '0;
        exp_araddr  = '0;
        exp_arlen   = '0;
        exp_arsize  = '0;
        exp_arburst = '0;
    endtask

    task automatic predict();
        int ridx;
        p_s_arready = '0;
        p_winner    = -1;
        if (!rst && !exp_busy) begin
            for (int k = 0; k < R; k++) begin
                int j;
                j = (exp_ptr + k) % R;
                if (p_winner < 0 && s_arvalid[j] && exp_cnt[j] < MO) p_winner = j;
            end
            if (p_winner >= 0) p_s_arready[p_winner] = 1'b1;
        end
        ridx = int'(m_rid[MIDW-1 -: 2]);
        p_s_rvalid       = '0;
        p_s_rvalid[ridx] = m_rvalid;
        p_m_rready       = s_rready[ridx];
    endtask

    task automatic advance();
        int ridx;
        if (rst) begin
            model_reset();
            return;
        end
        predict();
        ridx = int'(m_rid[MIDW-1 -: 2]);
        if (exp_busy) begin
            if (m_arready) exp_busy = 1'b0;
        end else if (p_winner >= 0) begin
            exp_busy    = 1'b1;
            exp_arid    = {2'(p_winner), s_arid[p_winner*IDW +: IDW]};
            exp_araddr  = s_araddr[p_winner*AW +: AW];
            exp_arlen   = s_arlen[p_winner*8 +: 8];
            exp_arsize  = s_arsize[p_winner*3 +: 3];
            exp_arburst = s_arburst[p_winner*2 +: 2];
            exp_ptr     = (p_winner + 1) % R;
            exp_cnt[p_winner]++;
        end
        if (m_rvalid && p_m_rready && m_rlast && exp_cnt[ridx] > 0) exp_cnt[ridx]--;
    endtask

    task automatic tick();
        advance();
        @(negedge clk);
    endtask

    task automatic rand_payload(int i);
        s_arid[i*IDW +: IDW] = IDW'($urandom);
        s_araddr[i*AW +: AW] = {$urandom, $urandom};
        s_arlen[i*8 +: 8]    = 8'($urandom);
        s_arsize[i*3 +: 3]   = 3'($urandom);
        s_arburst[i*2 +: 2]  = 2'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;
        c_s_arvalid = '0; c_m_arready = 1'b0; c_m_rvalid = 1'b0; c_m_rlast = 1'b0; c_s_rready = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_arvalid = '1;
        c_s_arvalid = '1;
        @(negedge clk);
        model_reset();
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (s_arready !== '0 || c_s_arready !== '0) begin
                n_err++;
                $display("[TB] FAIL reset_arready cycle %0d: got %b/%b expected 0/0", c, s_arready, c_s_arready);
            end
            n_checks++;
            if (m_arvalid !== 1'b0 || c_m_arvalid !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL reset_m_arvalid cycle %0d: got %b/%b expected 0/0", c, m_arvalid, c_m_arvalid);
            end
            n_checks++;
            if (o_route_error !== 1'b0 || c_o_route_error !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL reset_route_error cycle %0d: got %b/%b expected 0/0", c, o_route_error, c_o_route_error);
            end
            n_checks++;
            if (m_arid !== '0 || m_araddr !== '0) begin
                n_err++;
                $display("[TB] FAIL reset_payload cycle %0d: got %h/%h expected 0/0", c, m_arid, m_araddr);
            end
            tick();
        end
        rst = 1'b0;
        s_arvalid = '0;
        c_s_arvalid = '0;
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        m_arready = 1'b1;
        for (int i = 0; i < R; i++) rand_payload(i);
        s_arvalid = '1;
        for (int c = 0; c < 10; c++) begin
            #1;
            predict();
            n_checks++;
            if (s_arready !== p_s_arready) begin
                n_err++;
                $display("[TB] FAIL rr_model_grant cycle %0d: got %b expected %b", c, s_arready, p_s_arready);
            end
            n_checks++;
            if (c % 2 == 0) begin
                if (s_arready !== (4'b0001 << order[c/2]) || m_arvalid !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL rr_order cycle %0d: got arready=%b arvalid=%b expected arready=%b arvalid=0",
                             c, s_arready, m_arvalid, 4'b0001 << order[c/2]);
                end
            end else begin
                if (s_arready !== 4'b0 || m_arvalid !== 1'b1 || m_arid[5:4] !== 2'(order[c/2])) begin
                    n_err++;
                    $display("[TB] FAIL rr_hold cycle %0d: got arready=%b arvalid=%b idx=%0d expected 0000/1/%0d",
                             c, s_arready, m_arvalid, m_arid[5:4], order[c/2]);
                end
            end
            tick();
            if (c % 2 == 0) rand_payload(order[c/2]);
        end
        s_arvalid = '0;
    endtask

    task automatic test_outstanding_limit();
        logic [R-1:0] hs;
        bit got;
        do_reset();
        m_arready = 1'b1;
        rand_payload(1);
        s_arvalid = 4'b0010;
        for (int c = 0; c < 16; c++) begin
            #1;
            predict();
            n_checks++;
            if (s_arready !== p_s_arready || s_arready !== ((c % 2 == 0) ? 4'b0010 : 4'b0000)) begin
                n_err++;
                $display("[TB] FAIL limit_fill cycle %0d: got %b expected %b", c, s_arready, p_s_arready);
            end
            tick();
            if (c % 2 == 0) rand_payload(1);
        end
        s_arvalid = 4'b0111;
        rand_payload(0);
        rand_payload(2);
        for (int c = 0; c < 16; c++) begin
            #1;
            predict();
            n_checks++;
            if (s_arready[1] !== 1'b0 || s_arready !== p_s_arready) begin
                n_err++;
                $display("[TB] FAIL limit_masked cycle %0d: got %b expected %b", c, s_arready, p_s_arready);
            end
            hs = s_arvalid & s_arready;
            tick();
            for (int i = 0; i < R; i++) if (hs[i]) rand_payload(i);
        end
        m_rvalid = 1'b1;
        m_rid    = {2'd1, 4'($urandom)};
        m_rlast  = 1'b1;
        s_rready = 4'b0010;
        #1;
        predict();
        n_checks++;
        if (m_rready !== 1'b1 || s_rvalid !== 4'b0010) begin
            n_err++;
            $display("[TB] FAIL limit_rlast: got rready=%b rvalid=%b expected 1/0010", m_rready, s_rvalid);
        end
        hs = s_arvalid & s_arready;
        tick();
        for (int i = 0; i < R; i++) if (hs[i]) rand_payload(i);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            #1;
            predict();
            n_checks++;
            if (s_arready !== p_s_arready) begin
                n_err++;
                $display("[TB] FAIL limit_release_model cycle %0d: got %b expected %b", c, s_arready, p_s_arready);
            end
            if (s_arready[1]) got = 1'b1;
            hs = s_arvalid & s_arready;
            tick();
            for (int i = 0; i < R; i++) if (hs[i]) rand_payload(i);
        end
        n_checks++;
        if (got !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL limit_release: got granted=%b expected 1", got);
        end
        s_arvalid = '0;
    endtask

    task automatic test_hold_stall();
        logic [IDW-1:0] want_id;
        logic [AW-1:0]  want_addr;
        logic [12:0]    want_ctl;
        do_reset();
        m_arready = 1'b0;
        rand_payload(3);
        s_arvalid = 4'b1000;
        want_id   = s_arid[3*IDW +: IDW];
        want_addr = s_araddr[3*AW +: AW];
        want_ctl  = {s_arlen[31:24], s_arsize[11:9], s_arburst[7:6]};
        #1;
        n_checks++;
        if (s_arready !== 4'b1000) begin
            n_err++;
            $display("[TB] FAIL hold_grant: got %b expected 1000", s_arready);
        end
        tick();
        s_arvalid = 4'b0111;
        for (int i = 0; i < R; i++) rand_payload(i);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (m_arvalid !== 1'b1 || s_arready !== 4'b0000) begin
                n_err++;
                $display("[TB] FAIL hold_handshake cycle %0d: got arvalid=%b arready=%b expected 1/0000", c, m_arvalid, s_arready);
            end
            n_checks++;
            if (m_arid !== {2'd3, want_id} || m_araddr !== want_addr || {m_arlen, m_arsize, m_arburst} !== want_ctl) begin
                n_err++;
                $display("[TB] FAIL hold_payload cycle %0d: got %h/%h/%h expected %h/%h/%h", c, m_arid, m_araddr,
                         {m_arlen, m_arsize, m_arburst}, {2'd3, want_id}, want_addr, want_ctl);
            end
            tick();
            rand_payload(3);
        end
        m_arready = 1'b1;
        tick();
        #1;
        n_checks++;
        if (m_arvalid !== 1'b0 || s_arready !== 4'b0001) begin
            n_err++;
            $display("[TB] FAIL hold_release: got arvalid=%b arready=%b expected 0/0001", m_arvalid, s_arready);
        end
        tick();
        s_arvalid = '0;
    endtask

    task automatic test_r_routing();
        do_reset();
        m_arready = 1'b1;
        rand_payload(2);
        s_arvalid = 4'b0100;
        tick();
        s_arvalid = '0;
        tick();
        for (int b = 0; b < 4; b++) begin
            bit done;
            m_rvalid = 1'b1;
            m_rid    = 6'h25;
            m_rdata  = {8{$urandom}};
            m_rresp  = 2'($urandom);
            m_rlast  = (b == 3);
            done     = 1'b0;
            for (int st = 0; st < 6 && !done; st++) begin
                s_rready = 4'($urandom);
                if (st == 0) s_rready[2] = 1'b0;
                if (st >= 2) s_rready[2] = 1'b1;
                #1;
                n_checks++;
                if (s_rvalid !== 4'b0100 || m_rready !== s_rready[2]) begin
                    n_err++;
                    $display("[TB] FAIL route_valid beat %0d stall %0d: got rvalid=%b rready=%b expected 0100/%b",
                             b, st, s_rvalid, m_rready, s_rready[2]);
                end
                n_checks++;
                if (s_rid !== 4'h5 || s_rresp !== m_rresp || s_rlast !== m_rlast || s_rdata !== m_rdata) begin
                    n_err++;
                    $display("[TB] FAIL route_payload beat %0d: got id=%h resp=%b last=%b expected 5/%b/%b",
                             b, s_rid, s_rresp, s_rlast, m_rresp, m_rlast);
                end
                done = s_rready[2];
                tick();
            end
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;
    endtask

    task automatic test_route_error();
        do_reset();
        for (int b = 0; b < 3; b++) begin
            c_m_rvalid = 1'b1;
            c_m_rid    = {2'd3, 4'($urandom)};
            c_m_rlast  = (b == 2);
            c_s_rready = 3'b000;
            #1;
            n_checks++;
            if (c_m_rready !== 1'b1 || c_s_rvalid !== 3'b000 || c_o_route_error !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL bad_idx_beat %0d: got rready=%b rvalid=%b err=%b expected 1/000/0",
                         b, c_m_rready, c_s_rvalid, c_o_route_error);
            end
            tick();
            c_m_rvalid = 1'b0;
            #1;
            n_checks++;
            if (c_o_route_error !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL bad_idx_pulse %0d: got %b expected 1", b, c_o_route_error);
            end
            tick();
        end
        c_m_rvalid = 1'b1;
        c_m_rid    = {2'd1, 4'h0};
        c_m_rlast  = 1'b0;
        c_s_rready = 3'b010;
        #1;
        n_checks++;
        if (c_s_rvalid !== 3'b010 || c_m_rready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL good_idx_route: got rvalid=%b rready=%b expected 010/1", c_s_rvalid, c_m_rready);
        end
        tick();
        c_m_rvalid = 1'b0;
        #1;
        n_checks++;
        if (c_o_route_error !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL good_idx_no_error: got %b expected 0", c_o_route_error);
        end
        tick();
        c_m_arready = 1'b1;
        c_s_arvalid = 3'b001;
        #1;
        n_checks++;
        if (c_s_arready !== 3'b001) begin
            n_err++;
            $display("[TB] FAIL sim_first_grant: got %b expected 001", c_s_arready);
        end
        tick();
        c_s_arvalid = 3'b000;
        tick();
        c_s_arvalid = 3'b001;
        c_m_rvalid  = 1'b1;
        c_m_rid     = {2'd0, 4'h7};
        c_m_rlast   = 1'b1;
        c_s_rready  = 3'b001;
        #1;
        n_checks++;
        if (c_s_arready !== 3'b001 || c_m_rready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL sim_grant_and_rlast: got arready=%b rready=%b expected 001/1", c_s_arready, c_m_rready);
        end
        tick();
        c_s_arvalid = 3'b000;
        c_m_rvalid  = 1'b0;
        c_m_rlast   = 1'b0;
        tick();
        c_s_arvalid = 3'b001;
        #1;
        n_checks++;
        if (c_s_arready !== 3'b001) begin
            n_err++;
            $display("[TB] FAIL sim_regrant: got %b expected 001", c_s_arready);
        end
        tick();
        c_s_arvalid = 3'b000;
        tick();
        c_s_arvalid = 3'b001;
        #1;
        n_checks++;
        if (c_s_arready !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL sim_limit_mask: got %b expected 000", c_s_arready);
        end
        tick();
        c_s_arvalid = 3'b000;
        c_m_arready = 1'b0;
    endtask

    task automatic test_random();
        logic [R-1:0] hs;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < R; i++) begin
                if (!s_arvalid[i] && $urandom_range(0, 2) == 0) begin
                    s_arvalid[i] = 1'b1;
                    rand_payload(i);
                end
            end
            m_arready = 1'($urandom_range(0, 1));
            s_rready  = 4'($urandom);
            m_rvalid  = 1'b0;
            m_rlast   = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                int pick;
                pick = $urandom_range(0, R - 1);
                if (exp_cnt[pick] > 0) begin
                    m_rvalid = 1'b1;
                    m_rid    = {2'(pick), 4'($urandom)};
                    m_rlast  = ($urandom_range(0, 2) == 0);
                    m_rdata  = {8{$urandom}};
                end
            end
            #1;
            predict();
            n_checks++;
            if (s_arready !== p_s_arready || m_arvalid !== exp_busy) begin
                n_err++;
                $display("[TB] FAIL rand_ar cycle %0d: got arready=%b arvalid=%b expected %b/%b",
                         c, s_arready, m_arvalid, p_s_arready, exp_busy);
            end
            if (exp_busy) begin
                n_checks++;
                if ({m_arid, m_araddr, m_arlen, m_arsize, m_arburst} !==
                    {exp_arid, exp_araddr, exp_arlen, exp_arsize, exp_arburst}) begin
                    n_err++;
                    $display("[TB] FAIL rand_payload cycle %0d: got %h/%h expected %h/%h",
                             c, m_arid, m_araddr, exp_arid, exp_araddr);
                end
            end
            n_checks++;
            if (s_rvalid !== p_s_rvalid || m_rready !== p_m_rready) begin
                n_err++;
                $display("[TB] FAIL rand_r cycle %0d: got rvalid=%b rready=%b expected %b/%b",
                         c, s_rvalid, m_rready, p_s_rvalid, p_m_rready);
            end
            hs = s_arvalid & s_arready;
            tick();
            s_arvalid = s_arvalid & ~hs;
        end
        s_arvalid = '0;
        m_rvalid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_arvalid = '0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; s_rready = '0;
        c_s_arvalid = '0; c_s_arid = '0; c_s_araddr = '0; c_s_arlen = '0; c_s_arsize = '0; c_s_arburst = '0;
        c_m_arready = 1'b0; c_m_rvalid = 1'b0; c_m_rid = '0; c_m_rdata = '0; c_m_rresp = '0; c_m_rlast = 1'b0;
        c_s_rready = '0;
        model_reset();
        test_reset();
        test_round_robin();
        test_outstanding_limit();
        test_hold_stall();
        test_r_routing();
        test_route_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
